cic_decim_ctrl: RTL and testbench

CIC_DECIM_CTRL -- requirements
Module: cic_decim_ctrl

---
 rtl/cic_ctrl_pkg.sv | 33 +++
 rtl/cic_phase_gen.sv | 58 +++++
 rtl/cic_decim_ctrl.sv | 155 +++++++++++++++
 tb/tb_cic_decim_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cic_ctrl_pkg
// Shared definitions for the CIC decimator control block:
//   - cic_state_t    : control FSM state encoding (IDLE is all-zero)
//   - DEC_LOG2_MIN/MAX: legal range of log2(decimation factor)
//   - DATA_W_DEF     : default CIC output word width
//   - CNT_W          : width of the phase counter (covers D up to 256)
//   - clamp_dec_log2 : folds an out-of-range dec_log2 into the legal range
// -----------------------------------------------------------------------------
package cic_ctrl_pkg;

    localparam int DATA_W_DEF   = 25;
    localparam int DEC_LOG2_MIN = 4;
    localparam int DEC_LOG2_MAX = 8;
    localparam int CNT_W        = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } cic_state_t;

    function automatic logic [3:0] clamp_dec_log2(input logic [3:0] v);
        if (v < 4'(DEC_LOG2_MIN)) begin
            return 4'(DEC_LOG2_MIN);
        end else if (v > 4'(DEC_LOG2_MAX)) begin
            return 4'(DEC_LOG2_MAX);
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/cic_phase_gen.sv
// -----------------------------------------------------------------------------
// cic_phase_gen
// Decimation phase counter. Counts 0..D-1 (D = 2^i_k) while i_run is high and
// is held at 0 otherwise. Produces the divided clock for the comb/output
// stages and a one-cycle strobe on the last phase of each period.
//
// Ports:
//   clk       in  modulator-rate clock
//   reset     in  asynchronous active-high reset
//   i_run     in  counter enable; low forces cnt and div_clk to 0
//   i_k       in  log2 of the decimation factor, already clamped to 4..8
//   o_div_clk out registered cnt[i_k-1]: 50% duty, period D, low when idle
//   o_strobe  out high for the single cycle in which cnt == D-1
// -----------------------------------------------------------------------------
module cic_phase_gen
    import cic_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_run,
    input  logic [3:0] i_k,
    output logic       o_div_clk,
    output logic       o_strobe
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_div_clk;
    logic [CNT_W:0]   w_d;
    logic [CNT_W:0]   w_d_m1;
    logic [CNT_W-1:0] w_last;
    logic [2:0]       w_msb;
    logic             w_wrap;

    // D = 2^k needs one bit more than the counter when k = 8; D-1 always fits.
    assign w_d    = 9'd1 << i_k;
    assign w_d_m1 = w_d - 9'd1;
    assign w_last = w_d_m1[CNT_W-1:0];
    // k-1 in 3 bits: k = 8 wraps to index 7, k = 4 gives index 3.
    assign w_msb  = i_k[2:0] - 3'd1;
    assign w_wrap = (r_cnt == w_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_div_clk <= 1'b0;
        end else if (!i_run) begin
            r_cnt     <= '0;
            r_div_clk <= 1'b0;
        end else begin
            r_cnt     <= w_wrap ? '0 : r_cnt + 8'd1;
            r_div_clk <= r_cnt[w_msb];
        end
    end

    assign o_div_clk = r_div_clk;
    assign o_strobe  = i_run && w_wrap;

endmodule

// File: rtl/cic_decim_ctrl.sv
// -----------------------------------------------------------------------------
// cic_decim_ctrl
// Control block for a CIC decimator: generates the divided clock and the
// decimation strobe, discards the first SETTLE_N decimated outputs after each
// start while the filter fills, then captures one sample per decimation period
// into a single-entry output register.
//
// Output handshake: sample_valid high means sample_data holds a sample not yet
// taken. A transfer happens in any cycle with sample_valid && sample_ready;
// sample_valid then drops the next cycle unless a new capture lands in that
// same cycle. A capture while sample_valid=1 and sample_ready=0 overwrites the
// old sample and sets the sticky overrun flag.
//
// Ports:
//   clk          in  modulator-rate clock (only clock)
//   reset        in  asynchronous active-high reset
//   enable       in  level run request
//   dec_log2     in  log2 of decimation factor, latched on start, clamped 4..8
//   cic_out      in  filter output word
//   div_clk      out divided clock for comb/output stages
//   dec_strobe   out one-cycle pulse per decimation period
//   sample_data  out captured decimated sample
//   sample_valid out sample_data holds an unconsumed sample
//   sample_ready in  consumer accepts the sample
//   overrun      out sticky: a sample was overwritten before acceptance
//   overrun_clr  in  synchronous clear of overrun (a new overrun wins)
//   busy         out FSM is not IDLE
//   dbg_state    out current FSM state, for observation
// -----------------------------------------------------------------------------
module cic_decim_ctrl
    import cic_ctrl_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int SETTLE_N = 3            // must be >= 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [3:0]        dec_log2,
    input  logic [DATA_W-1:0] cic_out,
    output logic              div_clk,
    output logic              dec_strobe,
    output logic [DATA_W-1:0] sample_data,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overrun,
    input  logic              overrun_clr,
    output logic              busy,
    output cic_state_t        dbg_state
);

    cic_state_t        r_state;
    cic_state_t        w_state_next;
    logic [3:0]        r_k_q;
    logic [7:0]        r_settle_cnt;
    logic [DATA_W-1:0] r_sample_data;
    logic              r_sample_valid;
    logic              r_overrun;
    logic              w_run;
    logic              w_strobe;
    logic              w_div_clk;
    logic              w_settle_done;
    logic              w_capture;

    // Dropping enable stops the counter on the same edge the FSM leaves for IDLE.
    assign w_run         = (r_state != IDLE) && enable;
    assign w_settle_done = (r_state == SETTLE) && w_strobe &&
                           (r_settle_cnt == 8'(SETTLE_N - 1));
    assign w_capture     = (r_state == RUN) && w_strobe;

    cic_phase_gen u_phase_gen (
        .clk       (clk),
        .reset     (reset),
        .i_run     (w_run),
        .i_k       (r_k_q),
        .o_div_clk (w_div_clk),
        .o_strobe  (w_strobe)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (enable) w_state_next = SETTLE;
            end
            SETTLE: begin
                if (!enable)            w_state_next = IDLE;
                else if (w_settle_done) w_state_next = RUN;
            end
            RUN: begin
                if (!enable) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Decimation factor is frozen for the whole run; only sampled on start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_k_q <= 4'(DEC_LOG2_MIN);
        end else if ((r_state == IDLE) && enable) begin
            r_k_q <= clamp_dec_log2(dec_log2);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_settle_cnt <= '0;
        end else if (!w_run) begin
            r_settle_cnt <= '0;
        end else if ((r_state == SETTLE) && w_strobe) begin
            r_settle_cnt <= r_settle_cnt + 8'd1;
        end
    end

    // ---------------- output register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sample_data  <= '0;
            r_sample_valid <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            if (w_capture) begin
                r_sample_data  <= cic_out;
                r_sample_valid <= 1'b1;
            end else if (r_sample_valid && sample_ready) begin
                r_sample_valid <= 1'b0;
            end

            if (w_capture && r_sample_valid && !sample_ready) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign div_clk      = w_div_clk;
    assign dec_strobe   = w_strobe;
    assign sample_data  = r_sample_data;
    assign sample_valid = r_sample_valid;
    assign overrun      = r_overrun;
    assign busy         = (r_state != IDLE);
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_cic_decim_ctrl.sv
module tb_cic_decim_ctrl;
    import cic_ctrl_pkg::*;

    localparam int DW = 25;

    typedef struct {
        logic [3:0] dl;
        int         exp_d;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [3:0]    dec_log2;
    logic [DW-1:0] cic_out;
    logic          div_clk;
    logic          dec_strobe;
    logic [DW-1:0] sample_data;
    logic          sample_valid;
    logic          sample_ready;
    logic          overrun;
    logic          overrun_clr;
    logic          busy;
    cic_state_t    dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int tcyc     = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    cic_decim_ctrl #(.DATA_W(DW), .SETTLE_N(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .dec_log2     (dec_log2),
        .cic_out      (cic_out),
        .div_clk      (div_clk),
        .dec_strobe   (dec_strobe),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr),
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, required end before 1000000");
        $fatal(1, "watchdog");
    end

    // ---------------- driver / checker tasks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the edge.
    // cic_out changes every cycle so a capture one cycle off is visible.
    task automatic tick();
        @(posedge clk);
        #1;
        tcyc++;
        cic_out = DW'(32'h00AB000 + 32'(tcyc));
    endtask

    task automatic wait_strobe(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (dec_strobe) begin
                at = tcyc;
                break;
            end
        end
        if (at < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL strobe_timeout: got no dec_strobe in %0d cycles, required one", limit);
        end
    endtask

    task automatic do_reset();
        enable       = 1'b0;
        sample_ready = 1'b0;
        overrun_clr  = 1'b0;
        reset        = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Start a run and walk through the settle phase. Returns on the cycle
    // after the first capture, with cnt back at 0.
    task automatic start_and_settle(input logic [3:0] dl, input int exp_d,
                                    output int last_s);
        int t_en;
        int s;
        dec_log2 = dl;
        enable   = 1'b1;
        t_en     = tcyc;
        last_s   = t_en;
        for (int n = 1; n <= 4; n++) begin
            wait_strobe(exp_d + 8, s);
            chk($sformatf("strobe%0d_spacing_dl%0d", n, dl), 32'(s - last_s), 32'(exp_d));
            chk("div_clk_high_at_strobe", 32'(div_clk), 32'd1);
            chk($sformatf("no_valid_before_strobe%0d", n), 32'(sample_valid), 32'd0);
            last_s = s;
        end
        exp_q.push_back(cic_out);
        tick();
        chk("first_capture_valid", 32'(sample_valid), 32'd1);
        chk("first_capture_data", 32'(sample_data), 32'(exp_q.pop_front()));
        chk("state_run", 32'(dbg_state), 32'(RUN));
    endtask

    // ---------------- test ----------------
    initial begin
        vec_t vecs[6];
        int   s_last;
        int   s;
        int   cnt;
        logic [DW-1:0] held;

        vecs[0] = '{4'd4,  16};
        vecs[1] = '{4'd2,  16};
        vecs[2] = '{4'd0,  16};
        vecs[3] = '{4'd5,  32};
        vecs[4] = '{4'd12, 256};
        vecs[5] = '{4'd7,  128};

        reset        = 1'b0;
        enable       = 1'b0;
        dec_log2     = 4'd4;
        cic_out      = '0;
        sample_ready = 1'b0;
        overrun_clr  = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        chk("rst_div_clk", 32'(div_clk), 32'd0);
        chk("rst_strobe", 32'(dec_strobe), 32'd0);
        chk("rst_data", 32'(sample_data), 32'd0);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));

        // Table: clamping, strobe period, settle discard, frozen dec_log2, duty.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            start_and_settle(vecs[i].dl, vecs[i].exp_d, s_last);
            dec_log2 = ~vecs[i].dl;
            wait_strobe(vecs[i].exp_d + 8, s);
            chk($sformatf("period_after_dl_change_%0d", i), 32'(s - s_last), 32'(vecs[i].exp_d));
            cnt = 0;
            for (int j = 0; j < vecs[i].exp_d; j++) begin
                tick();
                if (div_clk) cnt++;
            end
            chk($sformatf("div_clk_high_time_%0d", i), 32'(cnt), 32'(vecs[i].exp_d / 2));
        end

        // Overrun: two captures without ready, then clear racing a new overrun.
        do_reset();
        start_and_settle(4'd4, 16, s_last);
        wait_strobe(24, s);
        exp_q.push_back(cic_out);
        tick();
        chk("ovr_set", 32'(overrun), 32'd1);
        chk("ovr_valid", 32'(sample_valid), 32'd1);
        chk("ovr_data_second", 32'(sample_data), 32'(exp_q.pop_front()));
        wait_strobe(24, s);
        exp_q.push_back(cic_out);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("ovr_set_beats_clr", 32'(overrun), 32'd1);
        chk("ovr_data_third", 32'(sample_data), 32'(exp_q.pop_front()));
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("ovr_clr", 32'(overrun), 32'd0);
        sample_ready = 1'b1;
        tick();
        sample_ready = 1'b0;
        chk("handshake_clears_valid", 32'(sample_valid), 32'd0);

        // Accept in the capture cycle: new data stays valid, no overrun.
        do_reset();
        start_and_settle(4'd4, 16, s_last);
        wait_strobe(24, s);
        exp_q.push_back(cic_out);
        sample_ready = 1'b1;
        tick();
        sample_ready = 1'b0;
        chk("accept_on_capture_valid", 32'(sample_valid), 32'd1);
        chk("accept_on_capture_data", 32'(sample_data), 32'(exp_q.pop_front()));
        chk("accept_on_capture_no_ovr", 32'(overrun), 32'd0);

        // Disable at cnt=7 in RUN with a pending sample, then restart.
        do_reset();
        start_and_settle(4'd4, 16, s_last);
        held = sample_data;
        repeat (7) tick();
        enable = 1'b0;
        tick();
        chk("dis_state_idle", 32'(dbg_state), 32'(IDLE));
        chk("dis_busy", 32'(busy), 32'd0);
        chk("dis_div_clk", 32'(div_clk), 32'd0);
        chk("dis_valid_held", 32'(sample_valid), 32'd1);
        chk("dis_data_held", 32'(sample_data), 32'(held));
        cnt = 0;
        for (int j = 0; j < 40; j++) begin
            tick();
            if (dec_strobe || div_clk) cnt++;
        end
        chk("idle_quiet", 32'(cnt), 32'd0);
        chk("idle_valid_still_held", 32'(sample_valid), 32'd1);
        sample_ready = 1'b1;
        tick();
        sample_ready = 1'b0;
        chk("idle_handshake", 32'(sample_valid), 32'd0);
        start_and_settle(4'd4, 16, s_last);

        // Asynchronous reset between edges in RUN.
        do_reset();
        start_and_settle(4'd4, 16, s_last);
        wait_strobe(24, s);
        tick();
        wait_strobe(24, s);
        chk("pre_rst_strobe", 32'(dec_strobe), 32'd1);
        chk("pre_rst_overrun", 32'(overrun), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_div_clk", 32'(div_clk), 32'd0);
        chk("arst_strobe", 32'(dec_strobe), 32'd0);
        chk("arst_data", 32'(sample_data), 32'd0);
        chk("arst_valid", 32'(sample_valid), 32'd0);
        chk("arst_overrun", 32'(overrun), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        enable = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_valid", 32'(sample_valid), 32'd0);
        chk("post_rst_state", 32'(dbg_state), 32'(IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
